// File: rtl/gray_rx_decoder.sv
// gray_rx_decoder
//   Receive end of a 4-bit Gray-coded position/pointer path crossing into the
//   clk domain. The Gray code is synchronised, decoded to registered binary,
//   and every code change is classified as a legal +1 step, a legal -1 step
//   or an illegal jump. A saturating counter tallies the legal steps.
//
// Parameters
//   SYNC_STAGES  synchroniser depth per input bit (2..4)
//
// Ports
//   clk          rising-edge clock
//   rst          synchronous active-high reset (overrides everything)
//   G1..G4       Gray input, G1 = LSB, asynchronous to clk
//   clr          synchronous clear of step_err and chg_cnt
//   B1..B4       registered decoded binary, B4 = MSB
//   valid        high once the first code has been captured after reset
//   up / dn      one-cycle pulse per accepted +1 / -1 step
//   step_err     sticky flag, set by any illegal change
//   chg_cnt      8-bit saturating count of legal steps
module gray_rx_decoder #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       G1,
    input  logic       G2,
    input  logic       G3,
    input  logic       G4,
    input  logic       clr,
    output logic       B1,
    output logic       B2,
    output logic       B3,
    output logic       B4,
    output logic       valid,
    output logic       up,
    output logic       dn,
    output logic       step_err,
    output logic [7:0] chg_cnt
);

    localparam logic [1:0] FILL  = 2'd0;
    localparam logic [1:0] PRIME = 2'd1;
    localparam logic [1:0] TRACK = 2'd2;

    localparam logic [2:0] FILL_LAST = 3'(SYNC_STAGES);

    function automatic logic [3:0] gray2bin(input logic [3:0] g);
        logic [3:0] b;
        b[3] = g[3];
        for (int i = 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    function automatic logic [7:0] sat_inc(input logic [7:0] c);
        return (c == 8'hFF) ? c : c + 8'd1;
    endfunction

    logic [3:0] sync_p [SYNC_STAGES];
    logic [3:0] gs;
    logic [3:0] prev_p1;
    logic [3:0] bin_p1;
    logic       vld_p1;
    logic [1:0] state;
    logic [2:0] fill_cnt;

    logic [3:0] bnew;
    logic [3:0] bold;
    logic [3:0] bold_inc;
    logic [3:0] bold_dec;
    logic       changed;
    logic       step_up;
    logic       step_dn;
    logic       step_bad;

    // ---- stage p0: input synchroniser ----
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_p[i] <= 4'd0;
            end
        end else begin
            sync_p[0] <= {G4, G3, G2, G1};
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_p[i] <= sync_p[i-1];
            end
        end
    end

    assign gs = sync_p[SYNC_STAGES-1];

    // ---- stage p1: decode and step classification ----
    always_comb begin
        bnew     = gray2bin(gs);
        bold     = gray2bin(prev_p1);
        bold_inc = bold + 4'd1;
        bold_dec = bold - 4'd1;
        changed  = (state == TRACK) && (gs != prev_p1);
        step_up  = changed && (bnew == bold_inc);
        step_dn  = changed && (bnew == bold_dec);
        step_bad = changed && !step_up && !step_dn;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= FILL;
            fill_cnt <= 3'd0;
            prev_p1  <= 4'd0;
            bin_p1   <= 4'd0;
            vld_p1   <= 1'b0;
            up       <= 1'b0;
            dn       <= 1'b0;
            step_err <= 1'b0;
            chg_cnt  <= 8'd0;
        end else begin
            up <= step_up;
            dn <= step_dn;

            case (state)
                FILL: begin
                    if (fill_cnt == FILL_LAST) begin
                        state <= PRIME;
                    end else begin
                        fill_cnt <= fill_cnt + 3'd1;
                    end
                end
                PRIME: begin
                    prev_p1 <= gs;
                    bin_p1  <= bnew;
                    vld_p1  <= 1'b1;
                    state   <= TRACK;
                end
                TRACK: begin
                    // Illegal changes are still accepted so tracking resumes
                    // from the new value.
                    if (changed) begin
                        prev_p1 <= gs;
                        bin_p1  <= bnew;
                    end
                end
                default: state <= FILL;
            endcase

            // Clear beats increment; a coincident illegal change beats clear.
            if (clr) begin
                chg_cnt <= 8'd0;
            end else if (step_up || step_dn) begin
                chg_cnt <= sat_inc(chg_cnt);
            end
            step_err <= step_bad || (step_err && !clr);
        end
    end

    assign valid = vld_p1;
    assign B1    = bin_p1[0];
    assign B2    = bin_p1[1];
    assign B3    = bin_p1[2];
    assign B4    = bin_p1[3];

endmodule

// File: tb/tb_gray_rx_decoder.sv
module tb_gray_rx_decoder;

    localparam int S = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       clr = 1'b0;
    logic [3:0] g   = 4'd0;
    logic       B1, B2, B3, B4, valid, up, dn, step_err;
    logic [7:0] chg_cnt;

    int total = 0;
    int bad   = 0;

    gray_rx_decoder #(.SYNC_STAGES(S)) dut (
        .clk(clk), .rst(rst),
        .G1(g[0]), .G2(g[1]), .G3(g[2]), .G4(g[3]),
        .clr(clr),
        .B1(B1), .B2(B2), .B3(B3), .B4(B4),
        .valid(valid), .up(up), .dn(dn),
        .step_err(step_err), .chg_cnt(chg_cnt)
    );

    always #5 clk = ~clk;

    function automatic int g2b(input logic [3:0] gc);
        int x;
        x = int'(gc);
        return (x ^ (x >> 1) ^ (x >> 2) ^ (x >> 3)) & 15;
    endfunction

    function automatic logic [3:0] b2g(input int b);
        logic [3:0] x;
        x = 4'(b);
        return x ^ (x >> 1);
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural reference: output at edge e depends only on the Gray values
    // sampled at edges e-S (current) and e-S-1 (previous) since reset release.
    int         e = -1;
    logic [3:0] hist[$];
    int         m_b = 0, m_cnt = 0;
    bit         m_valid = 0, m_up = 0, m_dn = 0, m_err = 0;

    initial begin
        bit         s_rst, s_clr, err_now;
        logic [3:0] s_g;
        int         cur, prv, d;
        forever begin
            @(posedge clk);
            s_rst = rst; s_clr = clr; s_g = g;
            if (s_rst) begin
                e = -1; hist.delete();
                m_b = 0; m_cnt = 0; m_valid = 0; m_up = 0; m_dn = 0; m_err = 0;
            end else begin
                e++;
                hist.push_back(s_g);
                m_up = 0; m_dn = 0; err_now = 0;
                if (e == S + 1) begin
                    m_b = g2b(hist[1]);
                    m_valid = 1;
                end else if (e > S + 1) begin
                    cur = g2b(hist[e-S]);
                    prv = g2b(hist[e-S-1]);
                    d = (cur - prv + 16) % 16;
                    if (d == 1) m_up = 1;
                    else if (d == 15) m_dn = 1;
                    else if (d != 0) err_now = 1;
                    m_b = cur;
                end
                if (s_clr) m_cnt = 0;
                else if (m_up || m_dn) m_cnt = (m_cnt >= 255) ? 255 : m_cnt + 1;
                m_err = err_now || (m_err && !s_clr);
            end
            #1;
            chk("B", int'({B4, B3, B2, B1}), m_b);
            chk("valid", int'(valid), int'(m_valid));
            chk("up", int'(up), int'(m_up));
            chk("dn", int'(dn), int'(m_dn));
            chk("step_err", int'(step_err), int'(m_err));
            chk("chg_cnt", int'(chg_cnt), m_cnt);
        end
    end

    int cur_b = 0;

    task automatic hold(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic put_bin(input int b, input int n);
        cur_b = b & 15;
        g = b2g(cur_b);
        hold(n);
    endtask

    // Called at a negedge with rst high; releases it and measures valid latency.
    task automatic release_and_time(input string name);
        int k;
        k = -1;
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #2;
            if (valid && k < 0) k = i;
        end
        chk(name, k, S + 1);
        @(negedge clk);
    endtask

    task automatic do_reset(input logic [3:0] code, input string name);
        rst = 1'b1; clr = 1'b0; g = code;
        cur_b = g2b(code);
        hold(3);
        release_and_time(name);
    endtask

    initial begin
        int r;
        @(negedge clk);

        // Reset and prime at 0000
        rst = 1'b1; g = 4'd0;
        hold(2);
        chk("rst_valid", int'(valid), 0);
        chk("rst_cnt", int'(chg_cnt), 0);
        release_and_time("prime_latency");
        chk("prime_B", int'({B4, B3, B2, B1}), 0);
        chk("prime_err", int'(step_err), 0);

        // Full up sequence 1..15, 0
        for (int b = 1; b <= 16; b++) put_bin(b, 4);
        chk("up16_cnt", int'(chg_cnt), 16);
        chk("up16_B", int'({B4, B3, B2, B1}), 0);
        chk("up16_err", int'(step_err), 0);

        // Down steps from binary 3
        do_reset(4'b0010, "prime3_latency");
        chk("prime3_B", int'({B4, B3, B2, B1}), 3);
        g = 4'b0011; hold(4);
        g = 4'b0001; hold(4);
        g = 4'b0000; hold(4);
        g = 4'b1000; hold(4);
        cur_b = 15;
        chk("dn4_B", int'({B4, B3, B2, B1}), 15);
        chk("dn4_cnt", int'(chg_cnt), 4);
        chk("dn4_err", int'(step_err), 0);

        // Illegal jump, clear, then legal down step
        do_reset(4'b0000, "prime0_latency");
        g = 4'b0100; cur_b = 7; hold(4);
        chk("jump_B", int'({B4, B3, B2, B1}), 7);
        chk("jump_err", int'(step_err), 1);
        chk("jump_cnt", int'(chg_cnt), 0);
        clr = 1'b1; hold(1); clr = 1'b0; hold(1);
        chk("clr_err", int'(step_err), 0);
        g = 4'b0101; cur_b = 6; hold(4);
        chk("after_clr_B", int'({B4, B3, B2, B1}), 6);
        chk("after_clr_cnt", int'(chg_cnt), 1);

        // Saturation, then clr coincident with an illegal jump
        for (int i = 0; i < 300; i++) put_bin(cur_b + 1, 4);
        chk("sat_cnt", int'(chg_cnt), 255);
        g = b2g(cur_b + 8); cur_b = (cur_b + 8) & 15;
        hold(S);
        clr = 1'b1; hold(1); clr = 1'b0; hold(2);
        chk("clr_jump_cnt", int'(chg_cnt), 0);
        chk("clr_jump_err", int'(step_err), 1);

        // Reset mid-count at B = 9, chg_cnt = 9
        do_reset(4'b0000, "prime_b_latency");
        for (int b = 1; b <= 9; b++) put_bin(b, 4);
        chk("mid_B", int'({B4, B3, B2, B1}), 9);
        chk("mid_cnt", int'(chg_cnt), 9);
        rst = 1'b1;
        @(posedge clk); #2;
        chk("mid_rst_B", int'({B4, B3, B2, B1}), 0);
        chk("mid_rst_valid", int'(valid), 0);
        chk("mid_rst_cnt", int'(chg_cnt), 0);
        chk("mid_rst_updn", int'({up, dn}), 0);
        @(negedge clk);
        release_and_time("reprime_latency");
        chk("reprime_B", int'({B4, B3, B2, B1}), 9);

        // Randomised traffic: legal steps, jumps, fast changes and clears
        for (int i = 0; i < 400; i++) begin
            r = $urandom_range(0, 9);
            if (r <= 2) put_bin(cur_b + 1, 4);
            else if (r <= 5) put_bin(cur_b + 15, 4);
            else if (r == 6) put_bin(cur_b + $urandom_range(2, 14), 4);
            else if (r == 7) put_bin(cur_b + $urandom_range(0, 15), $urandom_range(1, 2));
            else if (r == 8) begin
                cur_b = (cur_b + 1) & 15;
                g = b2g(cur_b);
                hold($urandom_range(0, 3));
                clr = 1'b1; hold(1); clr = 1'b0;
                hold(3);
            end else hold($urandom_range(1, 5));
        end
        hold(6);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
